// File: rtl/pipe_pkg.sv
// Shared constants and fetch FSM state type for the pipeline front end.
// Optional feature macro: PC_TRAP_EN (adds the TRAP state for odd redirect targets).
package pipe_pkg;

    localparam int unsigned DefaultN = 16;
    localparam logic [15:0] NOP      = 16'h0000;
    localparam logic [15:0] TRAP_VEC = 16'h00F0;

`ifdef PC_TRAP_EN
    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StTrap
    } fetch_state_e;
`else
    typedef enum logic {
        StBoot,
        StRun
    } fetch_state_e;
`endif

endpackage

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: pipeline control, instruction memory and IF/ID outputs.
// master drives control and memory data; slave is the fetch stage. PC_TRAP_EN adds trap.
interface pc_fetch_stage_if #(
    parameter int unsigned N = pipe_pkg::DefaultN
);
    logic         stall;
    logic         flush;
    logic         redirect;
    logic [N-1:0] redirect_pc;
    logic [N-1:0] instr_in;
    logic [N-1:0] pc;
    logic         if_id_valid;
    logic [N-1:0] if_id_instr;
    logic [N-1:0] if_id_pc;
    logic [N-1:0] if_id_pc_plus2;
`ifdef PC_TRAP_EN
    logic         trap;

    modport master (
        output stall, flush, redirect, redirect_pc, instr_in,
        input  pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus2, trap
    );

    modport slave (
        input  stall, flush, redirect, redirect_pc, instr_in,
        output pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus2, trap
    );
`else
    modport master (
        output stall, flush, redirect, redirect_pc, instr_in,
        input  pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus2
    );

    modport slave (
        input  stall, flush, redirect, redirect_pc, instr_in,
        output pc, if_id_valid, if_id_instr, if_id_pc, if_id_pc_plus2
    );
`endif
endinterface

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register with clear (wins), load and implicit hold.
// Clear only kills valid/instr; the address fields keep their last value.
module if_id_reg
    import pipe_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         clear,
    input  logic [N-1:0] instr_d,
    input  logic [N-1:0] pc_d,
    input  logic [N-1:0] pc_plus2_d,
    output logic         valid,
    output logic [N-1:0] instr,
    output logic [N-1:0] pc,
    output logic [N-1:0] pc_plus2
);

    logic         valid_q;
    logic [N-1:0] instr_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_plus2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q    <= 1'b0;
            instr_q    <= N'(NOP);
            pc_q       <= '0;
            pc_plus2_q <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
            instr_q <= N'(NOP);
        end else if (load) begin
            valid_q    <= 1'b1;
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus2_q <= pc_plus2_d;
        end
    end

    assign valid    = valid_q;
    assign instr    = instr_q;
    assign pc       = pc_q;
    assign pc_plus2 = pc_plus2_q;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and IF/ID register for a 16-bit-instruction pipeline.
// Optional macro PC_TRAP_EN: odd redirect targets trap to TRAP_VEC instead of being aligned.
module pc_fetch_stage
    import pipe_pkg::*;
#(
    parameter int unsigned  N        = DefaultN,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input logic             clk,
    input logic             reset_n,
    pc_fetch_stage_if.slave bus
);

    fetch_state_e state_q;
    logic [N-1:0] pc_q;
    logic [N-1:0] pc_plus2;
    logic [N-1:0] target;
    logic         ifid_load;
    logic         ifid_clear;

    assign pc_plus2 = pc_q + N'(2);

`ifdef PC_TRAP_EN
    logic trap_q;
    logic misaligned;

    assign target     = bus.redirect_pc;
    assign misaligned = bus.redirect_pc[0];
    assign bus.trap   = trap_q;
`else
    // Without trapping, odd targets are silently aligned down.
    assign target = bus.redirect_pc & ~N'(1);
`endif

    // IF/ID only moves in RUN; BOOT and TRAP leave it cleared from the prior event.
    always_comb begin
        ifid_load  = 1'b0;
        ifid_clear = 1'b0;
        if (state_q == StRun) begin
            if (bus.redirect || bus.flush) begin
                ifid_clear = 1'b1;
            end else if (!bus.stall) begin
                ifid_load = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StBoot;
            pc_q    <= RESET_PC;
`ifdef PC_TRAP_EN
            trap_q  <= 1'b0;
`endif
        end else begin
`ifdef PC_TRAP_EN
            trap_q <= 1'b0;
`endif
            case (state_q)
                StBoot: state_q <= StRun;
                StRun: begin
                    if (bus.redirect) begin
`ifdef PC_TRAP_EN
                        if (misaligned) begin
                            state_q <= StTrap;
                            pc_q    <= N'(TRAP_VEC);
                            trap_q  <= 1'b1;
                        end else begin
                            pc_q <= target;
                        end
`else
                        pc_q <= target;
`endif
                    end else if (!bus.stall) begin
                        // Covers both advance and flush-without-stall.
                        pc_q <= pc_plus2;
                    end
                end
`ifdef PC_TRAP_EN
                StTrap: state_q <= StRun;
`endif
                default: state_q <= StBoot;
            endcase
        end
    end

    assign bus.pc = pc_q;

    if_id_reg #(
        .N(N)
    ) u_if_id_reg (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (ifid_load),
        .clear      (ifid_clear),
        .instr_d    (bus.instr_in),
        .pc_d       (pc_q),
        .pc_plus2_d (pc_plus2),
        .valid      (bus.if_id_valid),
        .instr      (bus.if_id_instr),
        .pc         (bus.if_id_pc),
        .pc_plus2   (bus.if_id_pc_plus2)
    );

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: directed scenarios with literal expectations, then random
// control traffic checked every cycle against a behavioural fetch model.
module tb_pc_fetch_stage;
    import pipe_pkg::*;

    localparam int unsigned  N        = 16;
    localparam logic [N-1:0] RESET_PC = 16'h0000;
`ifdef PC_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    pc_fetch_stage_if #(.N(N)) bus ();

    pc_fetch_stage #(
        .N        (N),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    // Instruction memory image; override lets a test plant a specific word.
    logic         ovr_en  = 1'b0;
    logic [N-1:0] ovr_val = '0;

    function automatic logic [N-1:0] mem(input logic [N-1:0] a);
        return {a[7:0], ~a[15:8]} ^ 16'h3C5A;
    endfunction

    assign bus.instr_in = ovr_en ? ovr_val : mem(bus.pc);

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one step of the fetch rules per rising edge.
    logic [N-1:0] m_pc, m_instr, m_ipc, m_ipc2;
    logic         m_valid, m_trap;
    bit           m_boot, m_intrap;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pc = RESET_PC; m_valid = 1'b0; m_instr = NOP; m_ipc = '0; m_ipc2 = '0;
            m_boot = 1'b1; m_intrap = 1'b0; m_trap = 1'b0;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else if (m_intrap) begin
            m_intrap = 1'b0;
            m_trap   = 1'b0;
        end else begin
            m_trap = 1'b0;
            if (bus.redirect) begin
                m_valid = 1'b0;
                m_instr = NOP;
                if (TrapEn && bus.redirect_pc[0]) begin
                    m_pc = TRAP_VEC; m_trap = 1'b1; m_intrap = 1'b1;
                end else begin
                    m_pc = {bus.redirect_pc[N-1:1], 1'b0};
                end
            end else if (bus.flush) begin
                m_valid = 1'b0;
                m_instr = NOP;
                if (!bus.stall) m_pc = m_pc + 16'd2;
            end else if (!bus.stall) begin
                m_instr = ovr_en ? ovr_val : mem(m_pc);
                m_ipc   = m_pc;
                m_ipc2  = m_pc + 16'd2;
                m_valid = 1'b1;
                m_pc    = m_pc + 16'd2;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en && reset_n) begin
            check("model_pc", bus.pc, m_pc);
            check("model_valid", N'(bus.if_id_valid), N'(m_valid));
            check("model_instr", bus.if_id_instr, m_instr);
            if (m_valid) begin
                check("model_if_id_pc", bus.if_id_pc, m_ipc);
                check("model_if_id_pc_plus2", bus.if_id_pc_plus2, m_ipc2);
            end
`ifdef PC_TRAP_EN
            check("model_trap", N'(bus.trap), N'(m_trap));
`endif
        end
    end

    task automatic step(input logic st, input logic fl, input logic rd, input logic [N-1:0] rpc);
        bus.stall       = st;
        bus.flush       = fl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1);
    end

    logic         r_st, r_fl, r_rd;
    logic [N-1:0] r_pc;

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        @(negedge clk); #1;
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_valid", N'(bus.if_id_valid), 16'd0);
        check("rst_instr", bus.if_id_instr, 16'h0000);
        check("rst_if_id_pc", bus.if_id_pc, 16'h0000);
        check("rst_if_id_pc_plus2", bus.if_id_pc_plus2, 16'h0000);
        cmp_en  = 1'b1;
        reset_n = 1'b1;

        // Boot cycle holds pc, then sequential fetch.
        step(1'b0, 1'b0, 1'b0, '0);
        check("boot_pc", bus.pc, 16'h0000);
        check("boot_valid", N'(bus.if_id_valid), 16'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        check("adv1_pc", bus.pc, 16'h0002);
        check("adv1_valid", N'(bus.if_id_valid), 16'd1);
        check("adv1_instr", bus.if_id_instr, 16'h3CA5);
        step(1'b0, 1'b0, 1'b0, '0);
        check("adv2_pc", bus.pc, 16'h0004);
        step(1'b0, 1'b0, 1'b0, '0);
        check("adv3_pc", bus.pc, 16'h0006);

        // Three stall cycles at 0006.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            check("stall_pc", bus.pc, 16'h0006);
            check("stall_if_id_pc", bus.if_id_pc, 16'h0004);
            check("stall_if_id_pc_plus2", bus.if_id_pc_plus2, 16'h0006);
            check("stall_instr", bus.if_id_instr, 16'h38A5);
            check("stall_valid", N'(bus.if_id_valid), 16'd1);
        end
        step(1'b0, 1'b0, 1'b0, '0);
        check("resume_pc", bus.pc, 16'h0008);
        check("resume_if_id_pc", bus.if_id_pc, 16'h0006);
        step(1'b0, 1'b0, 1'b0, '0);
        check("pre_redirect_pc", bus.pc, 16'h000A);

        // Redirect wins over stall.
        step(1'b1, 1'b0, 1'b1, 16'h0040);
        check("redir_pc", bus.pc, 16'h0040);
        check("redir_valid", N'(bus.if_id_valid), 16'd0);
        check("redir_instr", bus.if_id_instr, 16'h0000);

        // Flush together with stall holds pc.
        step(1'b0, 1'b0, 1'b1, 16'h0010);
        check("goto10_pc", bus.pc, 16'h0010);
        step(1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b0, '0);
        check("flush_stall_pc", bus.pc, 16'h0012);
        check("flush_stall_valid", N'(bus.if_id_valid), 16'd0);
        step(1'b0, 1'b0, 1'b0, '0);
        check("post_flush_pc", bus.pc, 16'h0014);
        check("post_flush_if_id_pc", bus.if_id_pc, 16'h0012);

`ifndef PC_TRAP_EN
        step(1'b0, 1'b0, 1'b1, 16'h0043);
        check("odd_target_aligned", bus.pc, 16'h0042);
`endif

        // Wrap from FFFE to 0000.
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        check("wrap_pre_pc", bus.pc, 16'hFFFE);
        ovr_en = 1'b1; ovr_val = 16'h1234;
        step(1'b0, 1'b0, 1'b0, '0);
        ovr_en = 1'b0;
        check("wrap_pc", bus.pc, 16'h0000);
        check("wrap_if_id_pc", bus.if_id_pc, 16'hFFFE);
        check("wrap_if_id_pc_plus2", bus.if_id_pc_plus2, 16'h0000);
        check("wrap_instr", bus.if_id_instr, 16'h1234);

`ifdef PC_TRAP_EN
        step(1'b0, 1'b0, 1'b1, 16'h0041);
        check("trap_pulse", N'(bus.trap), 16'd1);
        check("trap_pc", bus.pc, 16'h00F0);
        check("trap_valid", N'(bus.if_id_valid), 16'd0);
        step(1'b1, 1'b1, 1'b1, 16'h0080);
        check("trap_end", N'(bus.trap), 16'd0);
        check("trap_ignores_inputs", bus.pc, 16'h00F0);
        step(1'b0, 1'b0, 1'b0, '0);
        check("trap_resume_pc", bus.pc, 16'h00F2);
`endif

        // Asynchronous reset mid-operation with redirect and stall pending.
        bus.stall = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 16'h0080;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        check("async_rst_pc", bus.pc, 16'h0000);
        check("async_rst_valid", N'(bus.if_id_valid), 16'd0);
        @(negedge clk); #1;
        reset_n = 1'b1;
        step(1'b1, 1'b0, 1'b1, 16'h0080);
        check("rst_boot_ignores_pc", bus.pc, 16'h0000);
        step(1'b0, 1'b0, 1'b0, '0);
        check("rst_first_adv_pc", bus.pc, 16'h0002);

        // Random control traffic.
        repeat (3000) begin
            r_rd = ($urandom_range(0, 9) == 0);
            r_fl = ($urandom_range(0, 9) == 0);
            r_st = ($urandom_range(0, 3) == 0);
            r_pc = N'($urandom);
            if ($urandom_range(0, 3) == 0) r_pc = 16'hFFF0 | (r_pc & 16'h000F);
`ifdef PC_TRAP_EN
            if ($urandom_range(0, 3) != 0) r_pc[0] = 1'b0;
`endif
            step(r_st, r_fl, r_rd, r_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
